// File: rtl/de1_input_debouncer.sv
// Pad synchronizer and debouncer for DE1 switches/keys: per-bit double-flop sync,
// consecutive-sample filter, edge pulses, sticky events and a maskable interrupt.

module de1_debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 240000,
    parameter int CNT_WIDTH       = 18
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    input  logic clr,
    output logic stable,
    output logic rise,
    output logic fall,
    output logic evt
);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic                 sync1;
    logic                 sync2;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 differ;
    logic                 accept;

    assign differ = (sync2 != stable);
    // The final disagreeing sample is the one that commits the new level.
    assign accept = differ && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            stable <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            rise <= accept & sync2;
            fall <= accept & ~sync2;
            if (!differ || accept) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (accept) begin
                stable <= sync2;
            end
        end
    end

    // A new edge in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt <= 1'b0;
        end else begin
            evt <= (evt & ~clr) | accept;
        end
    end
endmodule

module de1_input_debouncer #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 240000,
    parameter int CNT_WIDTH       = 18
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_n_i,
    input  logic [WIDTH-1:0] raw_i,
    output logic [WIDTH-1:0] stable_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    output logic [WIDTH-1:0] event_o,
    input  logic [WIDTH-1:0] event_clr_i,
    input  logic [WIDTH-1:0] irq_mask_i,
    output logic             irq_o
);
    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            de1_debounce_bit #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .CNT_WIDTH      (CNT_WIDTH)
            ) u_bit (
                .clk   (wb_clk_i),
                .rst_n (wb_rst_n_i),
                .raw   (raw_i[i]),
                .clr   (event_clr_i[i]),
                .stable(stable_o[i]),
                .rise  (rise_o[i]),
                .fall  (fall_o[i]),
                .evt   (event_o[i])
            );
        end
    endgenerate

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            irq_o <= 1'b0;
        end else begin
            irq_o <= |(event_o & irq_mask_i);
        end
    end
endmodule

// File: tb/tb_de1_input_debouncer.sv
// Directed bench for de1_input_debouncer with DEBOUNCE_CYCLES=4 (accept 6 edges after a raw change).

module tb_de1_input_debouncer;
    logic       clk;
    logic       rst_n;
    logic [7:0] raw;
    logic [7:0] stable;
    logic [7:0] rise;
    logic [7:0] fall;
    logic [7:0] evt;
    logic [7:0] clr;
    logic [7:0] mask;
    logic       irq;

    int passed = 0;
    int total  = 0;

    de1_input_debouncer #(
        .WIDTH          (8),
        .DEBOUNCE_CYCLES(4),
        .CNT_WIDTH      (18)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .raw_i      (raw),
        .stable_o   (stable),
        .rise_o     (rise),
        .fall_o     (fall),
        .event_o    (evt),
        .event_clr_i(clr),
        .irq_mask_i (mask),
        .irq_o      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        int rises;
        int first_at;

        rst_n = 1'b0;
        raw   = 8'h00;
        clr   = 8'h00;
        mask  = 8'h00;
        tick(2);
        chk("rst_stable", stable, 8'h00);
        chk("rst_rise", rise, 8'h00);
        chk("rst_fall", fall, 8'h00);
        chk("rst_event", evt, 8'h00);
        chk("rst_irq", {7'd0, irq}, 8'h00);
        rst_n = 1'b1;
        tick(2);

        // basic rise on bit 0
        mask = 8'h01;
        raw  = 8'h01;
        tick(5);
        chk("rise_early_stable", stable, 8'h00);
        chk("rise_early_pulse", rise, 8'h00);
        tick(1);
        chk("rise_stable", stable, 8'h01);
        chk("rise_pulse", rise, 8'h01);
        chk("rise_event", evt, 8'h01);
        chk("rise_irq_lag", {7'd0, irq}, 8'h00);
        tick(1);
        chk("rise_pulse_end", rise, 8'h00);
        chk("rise_irq", {7'd0, irq}, 8'h01);
        clr = 8'h01;
        tick(1);
        clr = 8'h00;
        chk("clr0_event", evt, 8'h00);
        tick(1);
        chk("clr0_irq", {7'd0, irq}, 8'h00);

        // glitch on bit 3, three cycles wide
        raw = 8'h09;
        tick(3);
        raw = 8'h01;
        rises = 0;
        for (int k = 0; k < 8; k++) begin
            tick(1);
            if (rise[3]) rises++;
        end
        chk("glitch_rises", 8'(rises), 8'h00);
        chk("glitch_stable", stable, 8'h01);
        chk("glitch_event", evt, 8'h00);

        // bounce on bit 1, then settle high
        rises = 0;
        for (int k = 0; k < 10; k++) begin
            raw[1] = ~raw[1];
            tick(2);
            if (rise[1]) rises++;
        end
        raw[1]   = 1'b1;
        first_at = 0;
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            if (rise[1]) begin
                rises++;
                if (first_at == 0) first_at = k;
            end
        end
        chk("bounce_rises", 8'(rises), 8'h01);
        chk("bounce_latency", 8'(first_at), 8'h06);
        chk("bounce_stable", stable, 8'h03);
        clr = 8'hFF;
        tick(1);
        clr = 8'h00;
        chk("clr_all", evt, 8'h00);

        // clear collides with fall on bit 2
        raw = 8'h07;
        tick(6);
        chk("b2_up", stable, 8'h07);
        clr = 8'hFF;
        tick(1);
        clr  = 8'h00;
        mask = 8'h04;
        tick(1);
        raw = 8'h03;
        tick(5);
        chk("b2_pre_fall", fall, 8'h00);
        clr = 8'h04;
        tick(1);
        chk("b2_fall", fall, 8'h04);
        chk("b2_set_wins", evt, 8'h04);
        chk("b2_stable", stable, 8'h03);
        tick(1);
        clr = 8'h00;
        chk("b2_cleared", evt, 8'h00);
        chk("b2_irq_hold", {7'd0, irq}, 8'h01);
        tick(1);
        chk("b2_irq_drop", {7'd0, irq}, 8'h00);

        // masking: bits 4 and 5 fire, only bit 4 enabled
        mask = 8'h10;
        raw  = 8'h33;
        tick(6);
        chk("mask_event", evt, 8'h30);
        chk("mask_rise", rise, 8'h30);
        tick(1);
        chk("mask_irq", {7'd0, irq}, 8'h01);
        clr = 8'h10;
        tick(1);
        clr = 8'h00;
        chk("mask_clr4", evt, 8'h20);
        tick(1);
        chk("mask_irq_drop", {7'd0, irq}, 8'h00);
        chk("mask_event5", evt, 8'h20);

        // reset while counting
        raw = 8'hFF;
        tick(4);
        chk("mid_no_rise", rise, 8'h00);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_stable", stable, 8'h00);
        chk("mid_rst_event", evt, 8'h00);
        chk("mid_rst_irq", {7'd0, irq}, 8'h00);
        rst_n = 1'b1;
        tick(5);
        chk("post_rst_early", rise, 8'h00);
        tick(1);
        chk("post_rst_rise", rise, 8'hFF);
        chk("post_rst_stable", stable, 8'hFF);
        chk("post_rst_event", evt, 8'hFF);
        tick(1);
        chk("post_rst_pulse_end", rise, 8'h00);
        chk("post_rst_no_fall", fall, 8'h00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
